// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl
//   Four-digit 7-segment display driver for a 14-bit binary value.
//   A programmable divider produces clk_div and a sample strobe on its rising
//   transition; each strobe latches the (saturated) input and runs a 14-step
//   sequential double-dabble conversion, then updates the registered BCD digits.
//   Optional build macro: BLANK_LEADING_ZEROS_EN (blank leading-zero digits).
module bcd_display_ctrl #(
  parameter int unsigned DIV   = 2499,
  parameter int unsigned DIV_W = 16
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [13:0] bin,
  output logic        clk_div,
  output logic        busy,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0,
  output logic [6:0]  HEX3_D,
  output logic [6:0]  HEX2_D,
  output logic [6:0]  HEX1_D,
  output logic [6:0]  HEX0_D
);

  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(DIV);
  localparam logic [13:0]      BIN_MAX  = 14'd9999;
  localparam logic [3:0]       LAST_IT  = 4'd13;

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  // Divider state
  logic [DIV_W-1:0] cnt;
  logic             strobe;

  // Converter state and next-state
  state_t      state, state_n;
  logic [3:0]  iter, iter_n;
  logic [13:0] sat, sat_n;
  logic [15:0] scratch, scratch_n;
  logic [15:0] bcd_q, bcd_n;

  // Datapath helpers for one double-dabble iteration
  logic [15:0] adj;
  logic [29:0] shifted;

  // Free-running divider: clk_div toggles every DIV+1 clocks
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (cnt == DIV_TC) begin
      cnt     <= '0;
      clk_div <= ~clk_div;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  // Sample strobe on the clock where clk_div is about to go 0->1
  always_comb begin
    strobe = (cnt == DIV_TC) && !clk_div;
  end

  // Converter state register
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      iter    <= '0;
      sat     <= '0;
      scratch <= '0;
      bcd_q   <= '0;
    end else begin
      state   <= state_n;
      iter    <= iter_n;
      sat     <= sat_n;
      scratch <= scratch_n;
      bcd_q   <= bcd_n;
    end
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,sat} left
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, sat} << 1;
  end

  // Converter next-state: sample on strobe, iterate 14 times, publish result
  always_comb begin
    state_n   = state;
    iter_n    = iter;
    sat_n     = sat;
    scratch_n = scratch;
    bcd_n     = bcd_q;
    unique case (state)
      S_IDLE: begin
        if (strobe) begin
          sat_n     = (bin > BIN_MAX) ? BIN_MAX : bin;
          scratch_n = '0;
          iter_n    = '0;
          state_n   = S_CONV;
        end
      end
      S_CONV: begin
        scratch_n = shifted[29:14];
        sat_n     = shifted[13:0];
        iter_n    = iter + 1'b1;
        if (iter == LAST_IT) begin
          // Result goes straight from the final shift to the output register,
          // so partial values in scratch are never visible on bcd3..0.
          bcd_n   = shifted[29:14];
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Status and registered digit outputs
  always_comb begin
    busy = (state == S_CONV);
    bcd3 = bcd_q[15:12];
    bcd2 = bcd_q[11:8];
    bcd1 = bcd_q[7:4];
    bcd0 = bcd_q[3:0];
  end

  // Full hex table, active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef BLANK_LEADING_ZEROS_EN
  logic blank3, blank2, blank1;

  // Segment decode with leading-zero blanking; the units digit is always lit
  always_comb begin
    blank3 = (bcd3 == 4'd0);
    blank2 = blank3 && (bcd2 == 4'd0);
    blank1 = blank2 && (bcd1 == 4'd0);
    HEX3_D = blank3 ? 7'h7F : seg7(bcd3);
    HEX2_D = blank2 ? 7'h7F : seg7(bcd2);
    HEX1_D = blank1 ? 7'h7F : seg7(bcd1);
    HEX0_D = seg7(bcd0);
  end
`else
  // Segment decode of all four digits, leading zeros shown
  always_comb begin
    HEX3_D = seg7(bcd3);
    HEX2_D = seg7(bcd2);
    HEX1_D = seg7(bcd1);
    HEX0_D = seg7(bcd0);
  end
`endif

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl
//   Scoreboard bench for bcd_display_ctrl with DIV=9 (strobe every 20 clocks).
//   Stimulus pushes the hand-computed expected digits/segments per sample;
//   a monitor pops and compares whenever busy falls (result published).
module tb_bcd_display_ctrl;

  logic        CLOCK_50;
  logic        rst;
  logic [13:0] bin;
  logic        clk_div;
  logic        busy;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  logic [6:0]  HEX3_D, HEX2_D, HEX1_D, HEX0_D;

  bcd_display_ctrl #(.DIV(9), .DIV_W(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .bin      (bin),
    .clk_div  (clk_div),
    .busy     (busy),
    .bcd3     (bcd3),
    .bcd2     (bcd2),
    .bcd1     (bcd1),
    .bcd0     (bcd0),
    .HEX3_D   (HEX3_D),
    .HEX2_D   (HEX2_D),
    .HEX1_D   (HEX1_D),
    .HEX0_D   (HEX0_D)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [15:0] bcd;
    logic [27:0] hex;
  } exp_t;

  typedef struct {
    logic [13:0] b;
    logic [15:0] bcd;
    logic [27:0] hex_off;
    logic [27:0] hex_on;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic busy_q   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Returns #1 after the clock edge on which clk_div rose (the sampling edge)
  task automatic wait_clkdiv_rise();
    logic prev;
    prev = clk_div;
    for (int n = 0; n < 200; n++) begin
      @(posedge CLOCK_50);
      #1;
      if (!prev && clk_div) return;
      prev = clk_div;
    end
    timeout_fail("clk_div_rise");
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0) return;
      @(posedge CLOCK_50);
    end
    timeout_fail("scoreboard_drain");
  endtask

  // Monitor: busy falling means a fresh result is on bcd3..0/HEX
  always @(negedge CLOCK_50) begin
    if (mon_en && busy_q && !busy) begin
      if (q.size() == 0) begin
        timeout_fail("unexpected_result");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, e.bcd});
        chk("hex", {4'h0, HEX3_D, HEX2_D, HEX1_D, HEX0_D}, {4'h0, e.hex});
      end
    end
    busy_q = busy;
  end

  vec_t vecs[11] = '{
    '{14'd1234,  16'h1234, {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}},
    '{14'd16383, 16'h9999, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}},
    '{14'd10000, 16'h9999, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}},
    '{14'd0,     16'h0000, {7'h40,7'h40,7'h40,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}},
    '{14'd9999,  16'h9999, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}},
    '{14'd7,     16'h0007, {7'h40,7'h40,7'h40,7'h78}, {7'h7F,7'h7F,7'h7F,7'h78}},
    '{14'd105,   16'h0105, {7'h40,7'h79,7'h40,7'h12}, {7'h7F,7'h79,7'h40,7'h12}},
    '{14'd5678,  16'h5678, {7'h12,7'h02,7'h78,7'h00}, {7'h12,7'h02,7'h78,7'h00}},
    '{14'd1009,  16'h1009, {7'h79,7'h40,7'h40,7'h10}, {7'h79,7'h40,7'h40,7'h10}},
    '{14'd10,    16'h0010, {7'h40,7'h40,7'h79,7'h40}, {7'h7F,7'h7F,7'h79,7'h40}},
    '{14'd8192,  16'h8192, {7'h00,7'h79,7'h10,7'h24}, {7'h00,7'h79,7'h10,7'h24}}
  };

  function automatic logic [27:0] pick_hex(input vec_t v);
`ifdef BLANK_LEADING_ZEROS_EN
    return v.hex_on;
`else
    return v.hex_off;
`endif
  endfunction

`ifdef BLANK_LEADING_ZEROS_EN
  localparam logic [27:0] HEX_RST = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
  localparam logic [27:0] HEX_RST = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

  initial begin
    int n;
    exp_t e;
    rst = 1'b1;
    bin = 14'd0;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("rst_clk_div", {31'h0, clk_div}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0);
    chk("rst_hex", {4'h0, HEX3_D, HEX2_D, HEX1_D, HEX0_D}, {4'h0, HEX_RST});
    rst = 1'b0;

    // Divider: 10 clocks high, 10 low; strobe (busy set) on the rising edge
    wait_clkdiv_rise();
    chk("strobe_sets_busy", {31'h0, busy}, 32'h1);
    n = 0;
    while (clk_div && n < 100) begin @(posedge CLOCK_50); #1; n++; end
    chk("clk_div_high_clocks", n, 10);
    n = 0;
    while (!clk_div && n < 100) begin @(posedge CLOCK_50); #1; n++; end
    chk("clk_div_low_clocks", n, 10);
    chk("strobe_sets_busy_2", {31'h0, busy}, 32'h1);
    // Sampling edge plus 14 shift edges: result lands on the 15th edge
    n = 0;
    while (busy && n < 100) begin @(posedge CLOCK_50); #1; n++; end
    chk("busy_high_clocks", n, 14);

    // Scoreboard phase; each new bin is applied while the previous conversion
    // is still running, so the latched value must be the one reported.
    repeat (2) @(posedge CLOCK_50);
    mon_en = 1'b1;
    foreach (vecs[i]) begin
      @(negedge CLOCK_50);
      bin   = vecs[i].b;
      e.bcd = vecs[i].bcd;
      e.hex = pick_hex(vecs[i]);
      q.push_back(e);
      wait_clkdiv_rise();
    end
    wait_drain();
    mon_en = 1'b0;

    // Reset 5 clocks into a conversion of 4321 aborts it immediately
    @(negedge CLOCK_50);
    bin = 14'd4321;
    wait_clkdiv_rise();
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("pre_abort_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0);
    chk("abort_clk_div", {31'h0, clk_div}, 32'h0);
    chk("abort_hex", {4'h0, HEX3_D, HEX2_D, HEX1_D, HEX0_D}, {4'h0, HEX_RST});
    repeat (2) @(negedge CLOCK_50);
    rst   = 1'b0;
    e.bcd = 16'h4321;
`ifdef BLANK_LEADING_ZEROS_EN
    e.hex = {7'h19, 7'h30, 7'h24, 7'h79};
`else
    e.hex = {7'h19, 7'h30, 7'h24, 7'h79};
`endif
    q.push_back(e);
    mon_en = 1'b1;
    wait_clkdiv_rise();
    wait_drain();
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
